// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit: opcodes, state encoding,
// IR field positions and the per-state strobe decode.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       mar_in;
    logic       zlow_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic [4:0] alu_op;
    logic       run;
    logic       illegal;
  } ctrl_out_t;

  // Strobes that should be visible while sitting in state st.
  // first_t1 qualifies PCin so the PC is written only once per fetch.
  function automatic ctrl_out_t ctrl_out_for(state_t st, logic first_t1,
                                             logic is_alu, logic is_illegal,
                                             logic [4:0] op);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_T0: begin
        o.pc_out  = 1'b1;
        o.mar_in  = 1'b1;
        o.inc_pc  = 1'b1;
        o.zlow_in = 1'b1;
        o.run     = 1'b1;
      end
      ST_T1: begin
        o.zlow_out = 1'b1;
        o.pc_in    = first_t1;
        o.read     = 1'b1;
        o.mdr_in   = 1'b1;
        o.run      = 1'b1;
      end
      ST_T2: begin
        o.mdr_out = 1'b1;
        o.ir_in   = 1'b1;
        o.run     = 1'b1;
      end
      ST_T3: begin
        o.run     = 1'b1;
        o.grb     = is_alu;
        o.r_out   = is_alu;
        o.y_in    = is_alu;
        o.illegal = is_illegal;
      end
      ST_T4: begin
        o.run     = 1'b1;
        o.grc     = 1'b1;
        o.r_out   = 1'b1;
        o.alu_op  = op;
        o.zlow_in = 1'b1;
      end
      ST_T5: begin
        o.run      = 1'b1;
        o.zlow_out = 1'b1;
        o.gra      = 1'b1;
        o.r_in     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier for the control sequencer.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_nop,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  // ALU ops occupy the contiguous range add..rol; everything unlisted is illegal.
  always_comb begin
    o_is_alu     = (i_opcode >= OP_ADD) && (i_opcode <= OP_ROL);
    o_is_nop     = (i_opcode == OP_NOP);
    o_is_halt    = (i_opcode == OP_HALT);
    o_is_illegal = !(o_is_alu || o_is_nop || o_is_halt);
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore sequencer: fetch, decode and the three-cycle register-register ALU
// sequence. Strobes are registered together with the state so every output
// changes only on a clock edge.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        MemRdy,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        ZLowIn,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  ALUop,
  output logic        Run,
  output logic        Illegal
);

  state_t     r_state;
  logic [4:0] r_opcode;
  logic       r_t1_busy;
  ctrl_out_t  r_out;

  state_t     w_next_state;
  logic [4:0] w_ir_op;
  logic [4:0] w_dec_op;
  logic       w_is_alu;
  logic       w_is_nop;
  logic       w_is_halt;
  logic       w_is_illegal;
  ctrl_out_t  w_next_out;
  logic       w_unused_ir;

  assign w_ir_op     = IR[IR_OP_MSB:IR_OP_LSB];
  assign w_unused_ir = &{1'b0, IR[IR_RA_MSB:0]};

  // In T2 the decoder looks at the opcode about to be latched so the T3
  // strobes can be registered on the same edge that enters T3.
  assign w_dec_op = (r_state == ST_T2) ? w_ir_op : r_opcode;

  ctrl_decode u_decode (
    .i_opcode     (w_dec_op),
    .o_is_alu     (w_is_alu),
    .o_is_nop     (w_is_nop),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  // Next-state selection; Stop is honoured only at instruction boundaries.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST:  w_next_state = ST_T0;
      ST_T0:   w_next_state = ST_T1;
      ST_T1:   w_next_state = MemRdy ? ST_T2 : ST_T1;
      ST_T2:   w_next_state = ST_T3;
      ST_T3: begin
        if (w_is_alu)
          w_next_state = ST_T4;
        else if (w_is_halt)
          w_next_state = ST_HALT;
        else if (w_is_nop || w_is_illegal)
          w_next_state = Stop ? ST_HALT : ST_T0;
        else
          w_next_state = ST_T0;
      end
      ST_T4:   w_next_state = ST_T5;
      ST_T5:   w_next_state = Stop ? ST_HALT : ST_T0;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_RST;
    endcase
  end

  // Strobes for the state being entered.
  always_comb begin
    w_next_out = ctrl_out_for(w_next_state, !r_t1_busy, w_is_alu,
                              w_is_illegal, w_dec_op);
  end

  // State, latched opcode, PCin first-cycle flag and registered strobes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_RST;
      r_opcode  <= '0;
      r_t1_busy <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state   <= w_next_state;
      r_t1_busy <= (w_next_state == ST_T1);
      r_out     <= w_next_out;
      if (r_state == ST_T2)
        r_opcode <= w_ir_op;
    end
  end

  assign PCout   = r_out.pc_out;
  assign Zlowout = r_out.zlow_out;
  assign MDRout  = r_out.mdr_out;
  assign MARin   = r_out.mar_in;
  assign ZLowIn  = r_out.zlow_in;
  assign PCin    = r_out.pc_in;
  assign MDRin   = r_out.mdr_in;
  assign IRin    = r_out.ir_in;
  assign Yin     = r_out.y_in;
  assign IncPC   = r_out.inc_pc;
  assign Read    = r_out.read;
  assign Gra     = r_out.gra;
  assign Grb     = r_out.grb;
  assign Grc     = r_out.grc;
  assign Rin     = r_out.r_in;
  assign Rout    = r_out.r_out;
  assign ALUop   = r_out.alu_op;
  assign Run     = r_out.run;
  assign Illegal = r_out.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle strobe pattern and the bench
// walks the DUT through the same cycles.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = '0;
  logic        MemRdy = 1'b0;
  logic        Stop = 1'b0;
  logic PCout, Zlowout, MDRout, MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout, Run, Illegal;
  logic [4:0] ALUop;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .MemRdy(MemRdy), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .ZLowIn(ZLowIn), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .ALUop(ALUop), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pcout, zlowout, mdrout, marin, zlowin, pcin, mdrin, irin, yin, incpc, read;
    logic gra, grb, grc, rin, rout;
    logic [4:0] aluop;
    logic run, illegal;
  } obs_t;

  typedef struct {
    obs_t        exp;
    logic        mr;
    logic        stop;
    logic [31:0] ir;
  } cyc_t;

  cyc_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic obs_t sample();
    obs_t s;
    s.pcout = PCout;  s.zlowout = Zlowout; s.mdrout = MDRout; s.marin = MARin;
    s.zlowin = ZLowIn; s.pcin = PCin;     s.mdrin = MDRin;   s.irin = IRin;
    s.yin = Yin;      s.incpc = IncPC;    s.read = Read;
    s.gra = Gra;      s.grb = Grb;        s.grc = Grc;       s.rin = Rin;
    s.rout = Rout;    s.aluop = ALUop;    s.run = Run;       s.illegal = Illegal;
    return s;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycles. nwait = MemRdy-low cycles in T1,
  // stop_b = Stop level at the instruction boundary, n_halt = HALT cycles to
  // expect afterwards if the instruction ends in HALT.
  task automatic push_instr(input logic [31:0] ir, input int nwait,
                            input logic stop_b, input int n_halt);
    logic [4:0] op;
    bit is_alu, is_halt, is_nop, goes_halt;
    cyc_t c;
    op      = ir[31:27];
    is_alu  = (op >= 5'd3) && (op <= 5'd10);
    is_nop  = (op == 5'd26);
    is_halt = (op == 5'd27);
    c.ir = ir;
    // T0
    c.exp = '0; c.exp.pcout = 1; c.exp.marin = 1; c.exp.incpc = 1;
    c.exp.zlowin = 1; c.exp.run = 1; c.mr = rbit(); c.stop = rbit();
    q.push_back(c);
    // T1 with wait states
    for (int k = 0; k <= nwait; k++) begin
      c.exp = '0; c.exp.zlowout = 1; c.exp.read = 1; c.exp.mdrin = 1;
      c.exp.run = 1; c.exp.pcin = (k == 0);
      c.mr = (k == nwait); c.stop = rbit();
      q.push_back(c);
    end
    // T2
    c.exp = '0; c.exp.mdrout = 1; c.exp.irin = 1; c.exp.run = 1;
    c.mr = rbit(); c.stop = rbit();
    q.push_back(c);
    // T3
    c.exp = '0; c.exp.run = 1;
    if (is_alu) begin c.exp.grb = 1; c.exp.rout = 1; c.exp.yin = 1; end
    c.exp.illegal = !(is_alu || is_nop || is_halt);
    c.mr = rbit();
    c.stop = (is_alu || is_halt) ? rbit() : stop_b;
    q.push_back(c);
    if (is_alu) begin
      c.exp = '0; c.exp.run = 1; c.exp.grc = 1; c.exp.rout = 1;
      c.exp.aluop = op; c.exp.zlowin = 1; c.mr = rbit(); c.stop = rbit();
      q.push_back(c);
      c.exp = '0; c.exp.run = 1; c.exp.zlowout = 1; c.exp.gra = 1; c.exp.rin = 1;
      c.mr = rbit(); c.stop = stop_b;
      q.push_back(c);
    end
    goes_halt = is_halt || stop_b;
    if (goes_halt) begin
      for (int k = 0; k < n_halt; k++) begin
        c.exp = '0; c.mr = rbit(); c.stop = rbit(); c.ir = $urandom;
        q.push_back(c);
      end
    end
  endtask

  task automatic run_q(input string name, input int n);
    cyc_t c;
    obs_t got;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(posedge Clock); #1;
      got = sample();
      n_tests++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, c.exp);
      end
      MemRdy = c.mr; Stop = c.stop; IR = c.ir;
    end
  endtask

  task automatic do_reset();
    q.delete();
    Reset = 1'b1; MemRdy = 1'b0; Stop = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    n_tests++;
    if (sample() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", sample());
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_and();
    do_reset();
    push_instr(32'h28918000, 0, 1'b0, 0);
    push_instr(32'h28918000, 0, 1'b0, 0);
    run_q("and_seq", 100);
  endtask

  task automatic test_shr_wait();
    do_reset();
    push_instr(32'h38000000, 3, 1'b0, 0);
    push_instr(32'h18000000, 1, 1'b0, 0);
    run_q("shr_wait", 100);
  endtask

  task automatic test_halt();
    do_reset();
    push_instr(32'hD8000000, 0, 1'b0, 20);
    run_q("halt", 100);
  endtask

  task automatic test_illegal();
    do_reset();
    push_instr(32'hF8000000, 0, 1'b0, 0);
    push_instr(32'hD0000000, 2, 1'b0, 0);
    push_instr(32'h20000000, 0, 1'b0, 0);
    run_q("illegal", 100);
  endtask

  task automatic test_stop();
    do_reset();
    push_instr(32'h18000000, 0, 1'b1, 10);
    run_q("stop_add", 100);
    do_reset();
    push_instr(32'hD0000000, 1, 1'b1, 8);
    run_q("stop_nop", 100);
  endtask

  task automatic test_reset_mid();
    obs_t e;
    do_reset();
    push_instr(32'h28918000, 0, 1'b0, 0);
    run_q("pre_reset", 5);
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if (sample() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_mid_t4: got %h expected 0", sample());
    end
    q.delete();
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; e.run = 1;
    n_tests++;
    if (sample() !== e) begin
      n_fail++;
      $display("FAIL reset_release_t0: got %h expected %h", sample(), e);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    int sel;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) op = 5'(sel + 3);
      else if (sel == 8) op = 5'd26;
      else begin
        op = 5'($urandom_range(0, 31));
        while ((op >= 5'd3 && op <= 5'd10) || op == 5'd26 || op == 5'd27)
          op = 5'($urandom_range(0, 31));
      end
      push_instr({op, 27'($urandom)}, $urandom_range(0, 3), 1'b0, 0);
    end
    push_instr({5'd27, 27'($urandom)}, $urandom_range(0, 3), 1'b0, 5);
    run_q("random", 1000);
  endtask

  initial begin
    test_reset();
    test_and();
    test_shr_wait();
    test_halt();
    test_illegal();
    test_stop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's register-transfer control lines. It replaces hand-sequenced stimulus with a Moore state machine that fetches an instruction, decodes the opcode in IR, and steps the three-cycle register-register ALU sequence. It sits directly upstream of the datapath. It consumes IR and a memory-ready strobe, and produces the PCout/MARin/Zlowout/… strobes, the Gra/Grb/Grc register-select lines and the 5-bit ALU operation code.

## Interface
- No parameters; opcode values and state encodings are constants in `cpu_ctrl_pkg`.
- `Clock  in  1`  system clock; all state changes occur on its rising edge.
- `Reset  in  1`  asynchronous, active-high reset.
- `IR  in  32`  instruction register contents; opcode in `IR[31:27]`.
- `MemRdy  in  1`  memory read data valid on Mdatain.
- `Stop  in  1`  level request to halt at the next instruction boundary.
- `PCout, Zlowout, MDRout, MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each`  datapath strobes.
- `Gra, Grb, Grc, Rin, Rout  out  1 each`  register-select and general-register enables.
- `ALUop  out  5`  ALU operation; equals opcode during T4, 0 otherwise.
- `Run  out  1`  high while executing; low in reset and HALT.
- `Illegal  out  1`  one-cycle pulse in T3 on an unsupported opcode.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, HALT. The outputs are pure functions of the state and the latched opcode (Moore machine).
- RST: the state entered on Reset. All outputs are 0 and Run=0. On the first edge after Reset deasserts, the machine goes to T0.
- T0: PCout, MARin, IncPC, ZLowIn. The next state is T1.
- T1: Zlowout, PCin, Read, MDRin.
  - PCin is asserted only on the first cycle of T1 (tracked by a 1-bit flag).
  - Read and MDRin hold while MemRdy=0.
  - The machine advances to T2 on the edge where MemRdy=1.
- T2: MDRout, IRin. The next state is T3.
- T3: the opcode is latched from `IR[31:27]` on entry, and the latched copy is used through T5.
- ALU opcodes are add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALUop=opcode, ZLowIn.
  - T5: Zlowout, Gra, Rin.
- nop 11010: T3 asserts nothing, and the machine returns to T0.
- halt 11011: T3 asserts nothing, and the machine goes to HALT.
- Any other opcode: Illegal pulses in T3, no register is written, and the machine returns to T0.
- Stop is sampled only at the instruction boundary (the T5 edge, or the T3 edge for nop/illegal).
  - If Stop=1 there, the next state is HALT; otherwise it is T0.
- HALT: all strobes are 0 and Run=0. The state is held until Reset.

## Timing
- Each state lasts one clock cycle, except T1, which lasts 1+N cycles where N is the number of MemRdy-low cycles.
- ALU instruction latency: 6 cycles (T0 to T5) with MemRdy tied high. A new T0 follows T5 on the next cycle.
- Outputs change only after rising edges; they are glitch-free because they are decoded from registered state.
- Reset asserted in any state, including mid-instruction: the state goes to RST immediately (asynchronous), all outputs go to 0, and the latched opcode clears to 0.
- Stop asserted mid-instruction: the current instruction completes; the halt takes effect at the boundary.
- MemRdy is ignored outside T1.

## Structure
- `cpu_ctrl_pkg` contains:
  - the opcode localparams;
  - the state encoding (4-bit, one constant per state);
  - the IR field positions for opcode, Ra, Rb and Rc.
- One sub-module, `ctrl_decode`: combinational; maps the latched opcode to `is_alu`, `is_nop`, `is_halt` and `is_illegal`.
- The sequencer FSM and output decode live in `control_sequencer`.

## Test plan
- Reset mid-T4 -> all outputs 0 in the same cycle; T0 strobes appear on the first edge after Reset falls.
- IR=0x28918000 (and, Ra=1, Rb=2, Rc=3), MemRdy=1 -> exact T0..T5 strobe sequence; ALUop=00101 only in T4; Gra+Rin only in T5; back to T0 at cycle 7.
- IR=0x38000000 (shr), MemRdy low for 3 cycles in T1 -> Read and MDRin held for 4 cycles, PCin high for 1 cycle; ALUop=00111 in T4.
- IR=0xD8000000 (halt) -> HALT after T3, Run=0, strobes stay 0 for 20 cycles.
- IR=0xF8000000 (opcode 11111) -> Illegal=1 for exactly one cycle, Rin never asserted, next state T0.
- Stop raised during T3 of an add -> T4 and T5 complete, Run=0 after T5, no further T0.
